// File: rtl/controlador_funcionalidade.sv
// controlador_funcionalidade
// Consumes the 3-bit function code from the 7-to-3 encoder. It waits for the
// code to settle and for a debounced confirm press, then latches the code.
// The selected function runs for CF*RUN_UNIT cycles, with a one-hot activity
// vector. Completion, abort and selection errors are reported as
// single-cycle pulses. Every output comes straight from a flop.

module controlador_funcionalidade #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STABLE_CYCLES   = 3,
    parameter int RUN_UNIT        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] CF,
    input  logic       CONFIRMA,
    input  logic       CANCELA,
    output logic [6:0] FUNC_ATIVA,
    output logic [2:0] CF_LATCH,
    output logic       BUSY,
    output logic       DONE,
    output logic       ABORTADO,
    output logic       ERRO
);

    localparam int RUN_W = $clog2(7 * RUN_UNIT);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIM  = 2'd2
    } state_t;

    // Input synchronisers
    logic             confirma_meta_r;
    logic             confirma_sync_r;
    logic             cancela_meta_r;
    logic             cancela_sync_r;

    // Debounce and press detection
    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_level_r;
    logic             deb_level_d_r;
    logic             press_s;

    // CF stability qualification
    logic [2:0]       cf_prev_r;
    logic [STB_W-1:0] stab_cnt_r;
    logic             stable_s;

    // FSM state, run counter and registered outputs
    state_t           state_r;
    state_t           state_nx_s;
    logic [RUN_W-1:0] run_cnt_r;
    logic [RUN_W-1:0] run_cnt_nx_s;
    logic [RUN_W-1:0] run_len_s;
    logic [2:0]       cf_latch_r;
    logic [2:0]       cf_latch_nx_s;
    logic [6:0]       func_ativa_r;
    logic [6:0]       func_ativa_nx_s;
    logic             busy_r;
    logic             busy_nx_s;
    logic             done_r;
    logic             done_nx_s;
    logic             abortado_r;
    logic             abortado_nx_s;
    logic             erro_r;
    logic             erro_nx_s;

    // Maps a code 1..7 onto its activity bit; code 0 selects nothing
    function automatic logic [6:0] code_to_onehot(input logic [2:0] code);
        logic [6:0] vec;
        case (code)
            3'd1:    vec = 7'b0000001;
            3'd2:    vec = 7'b0000010;
            3'd3:    vec = 7'b0000100;
            3'd4:    vec = 7'b0001000;
            3'd5:    vec = 7'b0010000;
            3'd6:    vec = 7'b0100000;
            3'd7:    vec = 7'b1000000;
            default: vec = 7'b0000000;
        endcase
        return vec;
    endfunction

    // Two-flop synchronisers for the raw confirm and cancel inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            confirma_meta_r <= 1'b0;
            confirma_sync_r <= 1'b0;
            cancela_meta_r  <= 1'b0;
            cancela_sync_r  <= 1'b0;
        end else begin
            confirma_meta_r <= CONFIRMA;
            confirma_sync_r <= confirma_meta_r;
            cancela_meta_r  <= CANCELA;
            cancela_sync_r  <= cancela_meta_r;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_r     <= {DEB_W{1'b0}};
            deb_level_r   <= 1'b0;
            deb_level_d_r <= 1'b0;
        end else begin
            deb_level_d_r <= deb_level_r;
            if (confirma_sync_r != deb_level_r) begin
                if (deb_cnt_r == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level_r <= ~deb_level_r;
                    deb_cnt_r   <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r   <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end
        end
    end

    assign press_s = deb_level_r & ~deb_level_d_r;

    // CF stability counter: clears on any change, saturates once the code has settled
    always_ff @(posedge clk) begin
        if (rst) begin
            cf_prev_r  <= 3'd0;
            stab_cnt_r <= {STB_W{1'b0}};
        end else begin
            cf_prev_r <= CF;
            if (CF != cf_prev_r) begin
                stab_cnt_r <= {STB_W{1'b0}};
            end else if (stab_cnt_r != STB_W'(STABLE_CYCLES)) begin
                stab_cnt_r <= stab_cnt_r + STB_W'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    assign stable_s  = (stab_cnt_r == STB_W'(STABLE_CYCLES));
    // Run length is formed at counter width; 7*RUN_UNIT always fits in RUN_W bits
    assign run_len_s = RUN_W'(CF) * RUN_W'(RUN_UNIT);

    // Next-state, counter, latch and output decode; cancel outranks both press and expiry
    always_comb begin
        state_nx_s      = state_r;
        run_cnt_nx_s    = run_cnt_r;
        cf_latch_nx_s   = cf_latch_r;
        done_nx_s       = 1'b0;
        abortado_nx_s   = 1'b0;
        erro_nx_s       = 1'b0;
        func_ativa_nx_s = 7'b0000000;
        busy_nx_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_s && cancela_sync_r) begin
                    state_nx_s = IDLE;
                end else if (press_s && stable_s && (CF != 3'd0)) begin
                    state_nx_s    = RUN;
                    cf_latch_nx_s = CF;
                    run_cnt_nx_s  = run_len_s - RUN_W'(1);
                end else if (press_s) begin
                    erro_nx_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cancela_sync_r) begin
                    state_nx_s    = IDLE;
                    abortado_nx_s = 1'b1;
                end else if (run_cnt_r == {RUN_W{1'b0}}) begin
                    state_nx_s = FIM;
                    done_nx_s  = 1'b1;
                end else begin
                    run_cnt_nx_s = run_cnt_r - RUN_W'(1);
                end
            end
            FIM: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        if (state_nx_s == RUN) begin
            busy_nx_s       = 1'b1;
            func_ativa_nx_s = code_to_onehot(cf_latch_nx_s);
        end else begin
            busy_nx_s       = 1'b0;
            func_ativa_nx_s = 7'b0000000;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            run_cnt_r    <= {RUN_W{1'b0}};
            cf_latch_r   <= 3'd0;
            func_ativa_r <= 7'b0000000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            abortado_r   <= 1'b0;
            erro_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            run_cnt_r    <= run_cnt_nx_s;
            cf_latch_r   <= cf_latch_nx_s;
            func_ativa_r <= func_ativa_nx_s;
            busy_r       <= busy_nx_s;
            done_r       <= done_nx_s;
            abortado_r   <= abortado_nx_s;
            erro_r       <= erro_nx_s;
        end
    end

    assign FUNC_ATIVA = func_ativa_r;
    assign CF_LATCH   = cf_latch_r;
    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign ABORTADO   = abortado_r;
    assign ERRO       = erro_r;

endmodule
